leiwand_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU memory bus (valid/ready/addr/wdata/rdata/wen), alongside simple_mem as a second slave.
- CPU writes bytes into a small FIFO; block serialises them as 8N1 frames on `tx`.
- Bus rdata is zero when this block is not addressed, so the top level can OR slave read buses together.
- Gives firmware a console output besides the LED.

---
 rtl/leiwand_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_leiwand_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leiwand_uart_tx.sv
// leiwand_uart_tx: bus-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA, STATUS, DIVISOR, reserved (addr[3:2]).
module leiwand_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  state_t state, state_n;

  logic          hit, acc, wr;
  logic [1:0]    reg_sel;
  logic [15:0]   divisor, eff_div;
  logic          ovf;
  logic          full, empty, busy;
  logic          push_req, push, pop;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fcnt;
  logic [4:0]    cnt5;
  logic [31:0]   status;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic [15:0]   div_lat, div_n;
  logic          tx_n;
  logic          unused;

  assign hit     = valid && (addr[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit && !ready;
  assign wr      = acc && (wen != 4'b0000);
  assign reg_sel = addr[3:2];

  assign full     = (fcnt == CW'(FIFO_DEPTH));
  assign empty    = (fcnt == '0);
  assign busy     = (state != S_IDLE);
  assign push_req = wr && (reg_sel == 2'd0) && wen[0];
  assign push     = push_req && !full;

  assign cnt5   = 5'(fcnt);
  assign status = {24'b0, cnt5[3:0], ovf, busy, empty, full};

  assign eff_div   = (divisor == 16'd0) ? 16'd1 : divisor;
  assign irq_empty = empty && !busy;

  assign unused = ^{addr[1:0], wen[3:2], wdata[31:16]};

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ready   <= 1'b0;
      rdata   <= '0;
      divisor <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      ready <= acc;
      rdata <= '0;
      if (acc && (wen == 4'b0000)) begin
        unique case (reg_sel)
          2'd0: rdata <= '0;
          2'd1: rdata <= status;
          2'd2: rdata <= {16'b0, divisor};
          2'd3: rdata <= '0;
        endcase
      end
      if (wr && (reg_sel == 2'd2)) begin
        if (wen[0]) divisor[7:0]  <= wdata[7:0];
        if (wen[1]) divisor[15:8] <= wdata[15:8];
      end
      if (push_req && full)
        ovf <= 1'b1;
      else if (wr && (reg_sel == 2'd1) && wen[0] && wdata[3])
        ovf <= 1'b0;
    end
  end

  // FIFO storage carries no reset; validity is tracked by fcnt
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      div_lat <= 16'd1;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      div_lat <= div_n;
      tx      <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, so tx stays registered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    div_n   = div_lat;
    tx_n    = tx;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = mem[rptr];
          div_n   = eff_div;
          cnt_n   = eff_div - 16'd1;
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (cnt == 16'd0) begin
          state_n = S_DATA;
          cnt_n   = div_lat - 16'd1;
          bit_n   = 3'd0;
          tx_n    = shreg[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == 16'd0) begin
          cnt_n = div_lat - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = mem[rptr];
            div_n   = eff_div;
            cnt_n   = eff_div - 16'd1;
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_leiwand_uart_tx.sv
// tb_leiwand_uart_tx: scoreboard bench for the UART transmitter.
// A line monitor decodes frames and pops expected bytes from a queue.
module tb_leiwand_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [7:0]  sb [$];
  int unsigned starts [$];
  int          mon_d = 104;

  leiwand_uart_tx dut (
    .clk       (clk),
    .RST       (rst_n),
    .valid     (valid),
    .ready     (ready),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // line monitor: samples mid-bit using mon_d
  initial begin
    logic       act;
    int         t;
    int         idx;
    logic [7:0] byt;
    act = 1'b0;
    t = 0;
    byt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          t = 0;
          starts.push_back(cyc);
        end
      end else begin
        t++;
        if (t >= mon_d && ((t - mon_d / 2) % mon_d) == 0) begin
          idx = (t - mon_d / 2) / mon_d;
          if (idx >= 1 && idx <= 8) begin
            byt[idx-1] = tx;
          end else if (idx == 9) begin
            chk("stop_bit", tx, 1);
            if (sb.size() == 0) chk("unexp_frame", sb.size(), 1);
            else chk("rx_byte", byt, sb.pop_front());
            act = 1'b0;
          end
        end
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, output logic [31:0] r);
    int k;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wen   = w;
    wdata = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 4);
    chk("ack", ready, 1);
    r = rdata;
    valid = 1'b0;
    wen   = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w,
                    input logic [31:0] d);
    logic [31:0] r;
    bus(a, w, d, r);
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'b0000, 32'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (irq_empty !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", irq_empty, 1);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b,
                             input int d);
    logic [63:0] obs, exp;
    obs = '0;
    exp = '0;
    for (int n = 1; n <= 10 * d; n++) begin
      @(negedge clk);
      obs[n-1] = tx;
      exp[n-1] = frame_bit(b, (n - 1) / d);
      if (n == 10 * d) chk({tag, "_busy_last"}, irq_empty, 0);
    end
    chk(tag, obs, exp);
    @(negedge clk);
    chk({tag, "_busy_fall"}, irq_empty, 1);
  endtask

  initial begin
    int lows;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq_empty, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_ready", ready, 0);
    rd("status_rst", BASE + 4, 32'h2);
    rd("div_rst", BASE + 8, 32'd104);
    rd("txdata_rd", BASE + 0, 32'h0);
    rd("resv_rd", BASE + 12, 32'h0);

    wr(BASE + 8, 4'b0011, 32'd4);
    mon_d = 4;
    rd("div4", BASE + 8, 32'd4);
    wr(BASE + 0, 4'b0001, 32'h55);
    sb.push_back(8'h55);
    frame_check("frame55", 8'h55, 4);

    wr(BASE + 8, 4'b0011, 32'd0);
    mon_d = 1;
    wr(BASE + 0, 4'b0001, 32'hA3);
    sb.push_back(8'hA3);
    frame_check("frameA3", 8'hA3, 1);
    wait_idle(50);

    wr(BASE + 8, 4'b0011, 32'd1000);
    mon_d = 1000;
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      wr(BASE + 0, 4'b0001, 32'(8'h10 + i));
      if (i < 5) sb.push_back(8'(8'h10 + i));
    end
    rd("status_full", BASE + 4, 32'h4D);
    wr(BASE + 4, 4'b0001, 32'h8);
    rd("status_ovf_clr", BASE + 4, 32'h45);
    wait_idle(60000);
    chk("frame_count", starts.size(), 5);
    for (int i = 1; i < 5 && i < starts.size(); i++)
      chk("frame_gap", starts[i] - starts[i-1], 10000);
    chk("sb_drained", sb.size(), 0);

    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      valid = 1'b1;
      addr  = (j == 0) ? BASE + 32'h20 : 32'h0;
      wen   = 4'b0001;
      wdata = 32'h77;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("miss_ready", ready, 0);
        chk("miss_rdata", rdata, 0);
      end
      valid = 1'b0;
      wen   = '0;
    end
    rd("status_miss", BASE + 4, 32'h2);

    wr(BASE + 8, 4'b0011, 32'd20);
    mon_d = 20;
    for (int i = 0; i < 3; i++) wr(BASE + 0, 4'b0001, 32'h0);
    repeat (60) @(negedge clk);
    chk("mid_data_low", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", tx, 1);
    chk("async_irq", irq_empty, 1);
    chk("async_ready", ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_d = 104;
    rd("status_rst2", BASE + 4, 32'h2);
    rd("div_rst2", BASE + 8, 32'd104);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no_frames", lows, 0);
    chk("sb_empty_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
